// File: rtl/embertrail_data_mem_if.sv
// Request/response bundle between the Embertrail control unit (master) and its
// dual-lane data memory (slave). Lane 1 occupies the low half of each bus.
interface embertrail_data_mem_if #(
    parameter int DATA_W = 16
);
    logic [31:0]         iDataAddrBus;
    logic [2*DATA_W-1:0] iDataDataBus;
    logic                iDataMem1RW;
    logic                iDataMem2RW;
    logic                iData1BusEn;
    logic                iData2BusEn;
    logic [2*DATA_W-1:0] oDataDataBus;
    logic                oData1Ack;
    logic                oData2Ack;
    logic                oBusy;
    logic [1:0]          oAddrErr;
    logic [1:0]          oOverrun;

    modport master (
        output iDataAddrBus, iDataDataBus, iDataMem1RW, iDataMem2RW,
               iData1BusEn, iData2BusEn,
        input  oDataDataBus, oData1Ack, oData2Ack, oBusy, oAddrErr, oOverrun
    );

    modport slave (
        input  iDataAddrBus, iDataDataBus, iDataMem1RW, iDataMem2RW,
               iData1BusEn, iData2BusEn,
        output oDataDataBus, oData1Ack, oData2Ack, oBusy, oAddrErr, oOverrun
    );
endinterface

// File: rtl/embertrail_data_mem.sv
// Dual-lane data memory: two request lanes share one single-ported array and are
// serviced one per cycle, lane 1 before lane 2 when both arrive together.
module embertrail_data_mem #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic                  iClock,
    input  logic                  iResetN,
    embertrail_data_mem_if.slave  bus
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int LANE_AW = 16;

    typedef enum logic [1:0] {IDLE, SERV1, SERV2} state_t;

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [1:0]         w_en;
    logic [1:0]         w_rw;
    logic [1:0]         w_rise;
    logic [LANE_AW-1:0] w_addr  [2];
    logic [DATA_W-1:0]  w_wdata [2];

    logic [1:0]         r_en_d;
    logic [1:0]         r_pend;
    logic [1:0]         r_req_rw;
    logic [LANE_AW-1:0] r_req_addr [2];
    logic [DATA_W-1:0]  r_req_data [2];
    logic [DATA_W-1:0]  r_rd_data  [2];
    logic [1:0]         r_ack;
    logic [1:0]         r_addr_err;
    logic [1:0]         r_overrun;
    logic               r_busy;
    state_t             r_state;

    logic [1:0]         w_srv;
    logic               w_sel;
    logic [LANE_AW-1:0] w_srv_addr;
    logic [ADDR_W-1:0]  w_srv_idx;
    logic               w_srv_oor;
    logic               w_we;
    logic [1:0]         w_pend_next;

    assign w_en = {bus.iData2BusEn, bus.iData1BusEn};
    assign w_rw = {bus.iDataMem2RW, bus.iDataMem1RW};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign w_addr[gi]  = bus.iDataAddrBus[gi*LANE_AW +: LANE_AW];
            assign w_wdata[gi] = bus.iDataDataBus[gi*DATA_W +: DATA_W];
            assign w_rise[gi]  = w_en[gi] & ~r_en_d[gi];
            // A rising edge while the lane is still pending is an overrun, not a new request.
            assign w_pend_next[gi] = (r_pend[gi] & ~w_srv[gi]) | (w_rise[gi] & ~r_pend[gi]);
            assign bus.oDataDataBus[gi*DATA_W +: DATA_W] = r_rd_data[gi];
        end
    endgenerate

    // After serving lane 1, lane 2 gets the next slot; otherwise lane 1 wins.
    always_comb begin
        w_srv = 2'b00;
        if (r_state == SERV1) begin
            if (r_pend[1])      w_srv = 2'b10;
            else if (r_pend[0]) w_srv = 2'b01;
        end else begin
            if (r_pend[0])      w_srv = 2'b01;
            else if (r_pend[1]) w_srv = 2'b10;
        end
    end

    assign w_sel      = w_srv[1];
    assign w_srv_addr = r_req_addr[w_sel];
    assign w_srv_idx  = w_srv_addr[ADDR_W-1:0];
    assign w_srv_oor  = |w_srv_addr[LANE_AW-1:ADDR_W];
    assign w_we       = (|w_srv) & r_req_rw[w_sel] & ~w_srv_oor;

    always_ff @(posedge iClock) begin
        if (w_we) r_mem[w_srv_idx] <= r_req_data[w_sel];
    end

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            r_en_d     <= '0;
            r_pend     <= '0;
            r_req_rw   <= '0;
            r_ack      <= '0;
            r_addr_err <= '0;
            r_overrun  <= '0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
            for (int i = 0; i < 2; i++) begin
                r_req_addr[i] <= '0;
                r_req_data[i] <= '0;
                r_rd_data[i]  <= '0;
            end
        end else begin
            r_en_d     <= w_en;
            r_pend     <= w_pend_next;
            r_busy     <= |w_pend_next;
            r_overrun  <= w_rise & r_pend;
            r_addr_err <= '0;
            for (int i = 0; i < 2; i++) begin
                if (w_rise[i] && !r_pend[i]) begin
                    r_req_addr[i] <= w_addr[i];
                    r_req_data[i] <= w_wdata[i];
                    r_req_rw[i]   <= w_rw[i];
                end
                // Service sets the ack even if the enable already dropped; it clears next cycle.
                if (w_srv[i]) begin
                    r_ack[i]      <= 1'b1;
                    r_addr_err[i] <= w_srv_oor;
                    if (!r_req_rw[i]) r_rd_data[i] <= w_srv_oor ? '0 : r_mem[w_srv_idx];
                end else if (!w_en[i]) begin
                    r_ack[i]     <= 1'b0;
                    r_rd_data[i] <= '0;
                end
            end
            case (w_srv)
                2'b01:   r_state <= SERV1;
                2'b10:   r_state <= SERV2;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.oData1Ack = r_ack[0];
    assign bus.oData2Ack = r_ack[1];
    assign bus.oBusy     = r_busy;
    assign bus.oAddrErr  = r_addr_err;
    assign bus.oOverrun  = r_overrun;
endmodule

// File: tb/tb_embertrail_data_mem.sv
// Bench for embertrail_data_mem: directed vector table, hand-built overrun and
// reset sequences, then random dual-lane traffic against a serial memory model.
module tb_embertrail_data_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    embertrail_data_mem_if #(.DATA_W(16)) bus ();

    embertrail_data_mem #(.DATA_W(16), .ADDR_W(10), .INIT_FILE("")) dut (
        .iClock (clk),
        .iResetN(rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        en1;
        logic        rw1;
        logic [15:0] a1;
        logic [15:0] d1;
        logic        en2;
        logic        rw2;
        logic [15:0] a2;
        logic [15:0] d2;
        int          hold;   // edges with enable high after the capture edge
        logic [15:0] x1;     // expected lane 1 read data
        logic [15:0] x2;     // expected lane 2 read data
        logic [1:0]  xerr;   // expected address-error lanes
    } vec_t;

    logic [15:0] ref_mem [1024];
    bit          known   [1024];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ack1"},  32'(bus.oData1Ack), 32'd0);
        check({tag, " ack2"},  32'(bus.oData2Ack), 32'd0);
        check({tag, " data"},  bus.oDataDataBus,   32'd0);
        check({tag, " busy"},  32'(bus.oBusy),     32'd0);
        check({tag, " err"},   32'(bus.oAddrErr),  32'd0);
        check({tag, " ovr"},   32'(bus.oOverrun),  32'd0);
    endtask

    // Serial reference: lane 1 then lane 2, plain array semantics.
    function automatic void model_apply(input vec_t t, output logic [15:0] e1, output logic [15:0] e2,
                                        output logic [1:0] eerr, output logic [1:0] chk);
        logic        en [2];
        logic        rw [2];
        logic [15:0] a  [2];
        logic [15:0] d  [2];
        logic [15:0] val [2];
        en = '{t.en1, t.en2}; rw = '{t.rw1, t.rw2};
        a  = '{t.a1, t.a2};   d  = '{t.d1, t.d2};
        val = '{16'h0, 16'h0};
        eerr = 2'b00;
        chk  = 2'b11;
        for (int l = 0; l < 2; l++) begin
            if (en[l]) begin
                bit oor;
                int idx;
                oor = (a[l] >= 16'd1024);
                idx = int'(a[l] % 16'd1024);
                eerr[l] = oor;
                if (rw[l]) begin
                    if (!oor) begin
                        ref_mem[idx] = d[l];
                        known[idx]   = 1'b1;
                    end
                end else if (!oor) begin
                    val[l] = ref_mem[idx];
                    chk[l] = known[idx];
                end
            end
        end
        e1 = val[0];
        e2 = val[1];
    endfunction

    task automatic run_txn(input int id, input vec_t t, input logic [15:0] e1, input logic [15:0] e2,
                           input logic [1:0] eerr, input logic [1:0] chk);
        int s1, s2;
        string tag;
        s1 = t.en1 ? 1 : 0;
        s2 = t.en2 ? (t.en1 ? 2 : 1) : 0;
        $display("txn %0d: L1 en=%0b rw=%0b a=%h d=%h | L2 en=%0b rw=%0b a=%h d=%h | hold=%0d",
                 id, t.en1, t.rw1, t.a1, t.d1, t.en2, t.rw2, t.a2, t.d2, t.hold);
        bus.iDataAddrBus = {t.a2, t.a1};
        bus.iDataDataBus = {t.d2, t.d1};
        bus.iDataMem1RW  = t.rw1;
        bus.iDataMem2RW  = t.rw2;
        bus.iData1BusEn  = t.en1;
        bus.iData2BusEn  = t.en2;
        for (int k = 0; k <= t.hold; k++) begin
            logic        xa1, xa2;
            logic [15:0] xd1, xd2;
            tick();
            tag = $sformatf("txn%0d e%0d", id, k);
            xa1 = (s1 != 0) && (k >= s1);
            xa2 = (s2 != 0) && (k >= s2);
            xd1 = (xa1 && !t.rw1) ? e1 : 16'h0;
            xd2 = (xa2 && !t.rw2) ? e2 : 16'h0;
            check({tag, " ack1"}, 32'(bus.oData1Ack), 32'(xa1));
            check({tag, " ack2"}, 32'(bus.oData2Ack), 32'(xa2));
            if (chk[0]) check({tag, " rd1"}, 32'(bus.oDataDataBus[15:0]),  32'(xd1));
            if (chk[1]) check({tag, " rd2"}, 32'(bus.oDataDataBus[31:16]), 32'(xd2));
            check({tag, " busy"}, 32'(bus.oBusy), 32'((s1 > k) || (s2 > k)));
            check({tag, " err"},  32'(bus.oAddrErr),
                  32'({(s2 != 0) && (s2 == k) && eerr[1], (s1 != 0) && (s1 == k) && eerr[0]}));
            check({tag, " ovr"},  32'(bus.oOverrun), 32'd0);
        end
        bus.iData1BusEn = 1'b0;
        bus.iData2BusEn = 1'b0;
        tick();
        check_idle($sformatf("txn%0d release", id));
    endtask

    vec_t vecs [13];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t        t;
        logic [15:0] e1, e2;
        logic [1:0]  eerr, chk;
        int          id;

        //           en1  rw1  a1        d1        en2  rw2  a2        d2        hold x1        x2        xerr
        vecs[0]  = '{1'b1, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 2'b00};
        vecs[1]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 16'hBEEF, 16'h0000, 2'b00};
        vecs[2]  = '{1'b1, 1'b1, 16'h0010, 16'h1234, 1'b1, 1'b0, 16'h0010, 16'h0000, 2, 16'h0000, 16'h1234, 2'b00};
        vecs[3]  = '{1'b1, 1'b1, 16'h0020, 16'hAAAA, 1'b1, 1'b1, 16'h0020, 16'h5555, 2, 16'h0000, 16'h0000, 2'b00};
        vecs[4]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 16'h5555, 16'h0000, 2'b00};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h8000, 16'h0000, 1, 16'h0000, 16'h0000, 2'b10};
        vecs[6]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h7777, 2, 16'h1234, 16'h0000, 2'b00};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1, 16'h0000, 16'h7777, 2'b00};
        vecs[8]  = '{1'b1, 1'b1, 16'h0000, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 2'b00};
        vecs[9]  = '{1'b1, 1'b1, 16'h0400, 16'hDEAD, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 2'b01};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 16'h1111, 16'h0000, 2'b00};
        vecs[11] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 4, 16'hBEEF, 16'h0000, 2'b00};
        vecs[12] = '{1'b1, 1'b1, 16'h0030, 16'hFFFF, 1'b1, 1'b1, 16'h0031, 16'h0F0F, 2, 16'h0000, 16'h0000, 2'b00};

        bus.iDataAddrBus = '0;
        bus.iDataDataBus = '0;
        bus.iDataMem1RW  = 1'b0;
        bus.iDataMem2RW  = 1'b0;
        bus.iData1BusEn  = 1'b0;
        bus.iData2BusEn  = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check_idle("reset");
        #3 rst_n = 1'b1;
        tick();
        check_idle("post-reset");

        for (int i = 0; i < 13; i++) begin
            model_apply(vecs[i], e1, e2, eerr, chk);
            run_txn(i, vecs[i], vecs[i].x1, vecs[i].x2, vecs[i].xerr, 2'b11);
        end

        // Overrun: lane 2 re-requests while still queued behind lane 1.
        $display("txn ovr: L1 write 0050=A5A5, L2 read 0050 with re-request while pending");
        bus.iDataAddrBus = {16'h0050, 16'h0050};
        bus.iDataDataBus = {16'h0000, 16'hA5A5};
        bus.iDataMem1RW  = 1'b1;
        bus.iDataMem2RW  = 1'b0;
        bus.iData1BusEn  = 1'b1;
        bus.iData2BusEn  = 1'b1;
        tick();
        check("ovr e0 busy", 32'(bus.oBusy), 32'd1);
        bus.iData2BusEn = 1'b0;
        tick();
        check("ovr e1 ack1", 32'(bus.oData1Ack), 32'd1);
        check("ovr e1 ack2", 32'(bus.oData2Ack), 32'd0);
        check("ovr e1 ovr",  32'(bus.oOverrun),  32'd0);
        bus.iDataAddrBus = {16'h0051, 16'h0050};
        bus.iDataDataBus = {16'h9999, 16'hA5A5};
        bus.iDataMem2RW  = 1'b1;
        bus.iData2BusEn  = 1'b1;
        tick();
        check("ovr e2 ovr",  32'(bus.oOverrun), 32'b10);
        check("ovr e2 ack2", 32'(bus.oData2Ack), 32'd1);
        check("ovr e2 rd2",  32'(bus.oDataDataBus[31:16]), 32'hA5A5);
        tick();
        check("ovr e3 ovr",  32'(bus.oOverrun), 32'd0);
        check("ovr e3 busy", 32'(bus.oBusy),    32'd0);
        check("ovr e3 ack2", 32'(bus.oData2Ack), 32'd1);
        check("ovr e3 rd2",  32'(bus.oDataDataBus[31:16]), 32'hA5A5);
        bus.iData1BusEn = 1'b0;
        bus.iData2BusEn = 1'b0;
        tick();
        check_idle("ovr release");
        ref_mem[16'h0050] = 16'hA5A5;
        known[16'h0050]   = 1'b1;

        // Reset after lane 1's write commits but before lane 2's.
        $display("txn rst: dual write 0030=1357 / 0031=2468, reset between E1 and E2");
        bus.iDataAddrBus = {16'h0031, 16'h0030};
        bus.iDataDataBus = {16'h2468, 16'h1357};
        bus.iDataMem1RW  = 1'b1;
        bus.iDataMem2RW  = 1'b1;
        bus.iData1BusEn  = 1'b1;
        bus.iData2BusEn  = 1'b1;
        tick();
        tick();
        check("rst e1 ack1", 32'(bus.oData1Ack), 32'd1);
        check("rst e1 busy", 32'(bus.oBusy),     32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("rst async");
        bus.iData1BusEn = 1'b0;
        bus.iData2BusEn = 1'b0;
        tick();
        check_idle("rst held");
        #3 rst_n = 1'b1;
        ref_mem[16'h0030] = 16'h1357;
        known[16'h0030]   = 1'b1;
        tick();
        t = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 1'b0, 16'h0031, 16'h0000, 2, 16'h1357, 16'h0F0F, 2'b00};
        model_apply(t, e1, e2, eerr, chk);
        run_txn(100, t, 16'h1357, 16'h0F0F, 2'b00, 2'b11);

        // Random traffic, expectations from the serial model.
        id = 200;
        for (int n = 0; n < 200; n++) begin
            int lanes, last;
            lanes = $urandom_range(1, 3);
            t.en1 = lanes[0];
            t.en2 = lanes[1];
            t.rw1 = 1'($urandom_range(0, 1));
            t.rw2 = 1'($urandom_range(0, 1));
            t.a1  = ($urandom_range(0, 7) == 0) ? {6'($urandom_range(1, 63)), 10'($urandom_range(0, 1023))}
                                                : 16'(16'h0040 + $urandom_range(0, 7));
            t.a2  = ($urandom_range(0, 7) == 0) ? {6'($urandom_range(1, 63)), 10'($urandom_range(0, 1023))}
                                                : 16'(16'h0040 + $urandom_range(0, 7));
            t.d1  = 16'($urandom);
            t.d2  = 16'($urandom);
            last  = (t.en1 && t.en2) ? 2 : 1;
            t.hold = last + $urandom_range(0, 2);
            t.x1 = '0; t.x2 = '0; t.xerr = '0;
            model_apply(t, e1, e2, eerr, chk);
            run_txn(id + n, t, e1, e2, eerr, chk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
